// File: rtl/prim_ram_1p_arb_pkg.sv
// Shared types and constants for the two-port single-port-RAM arbiter.
package prim_ram_1p_arb_pkg;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } own_e;

  localparam int unsigned NumPorts = 2;

endpackage

// File: rtl/prim_ram_1p_arb_rr.sv
// Two-way round-robin picker: on a conflict the port other than `last` wins.
module prim_ram_1p_arb_rr
  import prim_ram_1p_arb_pkg::*;
(
  input  logic [NumPorts-1:0] req,
  input  logic                last,
  output logic [NumPorts-1:0] gnt
);

  // Combinational grant selection
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == OWN_A) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/prim_ram_1p_arb.sv
// Arbitrates requesters a and b onto one external single-port RAM with 1-cycle read latency.
// Optional macro PRIM_RAM_1P_ARB_FIXED_PRIO_EN: a always wins conflicts instead of round-robin.
module prim_ram_1p_arb
  import prim_ram_1p_arb_pkg::*;
#(
  parameter int Width = 32,
  parameter int Depth = 128,
  localparam int Aw = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,

  input  logic             a_req_i,
  output logic             a_gnt_o,
  input  logic             a_write_i,
  input  logic [Aw-1:0]    a_addr_i,
  input  logic [Width-1:0] a_wdata_i,
  input  logic [Width-1:0] a_wmask_i,
  output logic             a_rvalid_o,
  output logic [Width-1:0] a_rdata_o,

  input  logic             b_req_i,
  output logic             b_gnt_o,
  input  logic             b_write_i,
  input  logic [Aw-1:0]    b_addr_i,
  input  logic [Width-1:0] b_wdata_i,
  input  logic [Width-1:0] b_wmask_i,
  output logic             b_rvalid_o,
  output logic [Width-1:0] b_rdata_o,

  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic             ram_rvalid_i,
  input  logic [Width-1:0] ram_rdata_i,

  output logic             err_o
);

  logic [NumPorts-1:0] req_s;
  logic [NumPorts-1:0] gnt_s;
  logic                pend_vld_q, pend_vld_d;
  own_e                pend_own_q, pend_own_d;
  logic                err_q, err_d;

  assign req_s   = {b_req_i, a_req_i};
  assign a_gnt_o = gnt_s[0];
  assign b_gnt_o = gnt_s[1];
  assign err_o   = err_q;

`ifdef PRIM_RAM_1P_ARB_FIXED_PRIO_EN
  assign gnt_s = req_s[0] ? 2'b01 : {req_s[1], 1'b0};
`else
  own_e last_q, last_d;

  prim_ram_1p_arb_rr u_rr (
    .req  (req_s),
    .last (last_q),
    .gnt  (gnt_s)
  );

  always_comb begin
    last_d = last_q;
    if (gnt_s[1]) begin
      last_d = OWN_B;
    end else if (gnt_s[0]) begin
      last_d = OWN_A;
    end else begin
      last_d = last_q;
    end
  end

  // Reset to b so that a wins the first conflict
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= OWN_B;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_comb begin
    ram_req_o   = 1'b0;
    ram_write_o = 1'b0;
    ram_addr_o  = {Aw{1'b0}};
    ram_wdata_o = {Width{1'b0}};
    ram_wmask_o = {Width{1'b0}};
    if (gnt_s[0]) begin
      ram_req_o   = 1'b1;
      ram_write_o = a_write_i;
      ram_addr_o  = a_addr_i;
      ram_wdata_o = a_wdata_i;
      ram_wmask_o = a_wmask_i;
    end else if (gnt_s[1]) begin
      ram_req_o   = 1'b1;
      ram_write_o = b_write_i;
      ram_addr_o  = b_addr_i;
      ram_wdata_o = b_wdata_i;
      ram_wmask_o = b_wmask_i;
    end else begin
      ram_req_o   = 1'b0;
    end
  end

  // A read tag lives for exactly one cycle; unexpected RAM data sets the sticky error
  always_comb begin
    pend_vld_d = ram_req_o & ~ram_write_o;
    pend_own_d = gnt_s[1] ? OWN_B : OWN_A;
    err_d      = err_q | (ram_rvalid_i & ~pend_vld_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_vld_q <= 1'b0;
      pend_own_q <= OWN_A;
      err_q      <= 1'b0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_own_q <= pend_own_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    a_rvalid_o = ram_rvalid_i & pend_vld_q & (pend_own_q == OWN_A);
    b_rvalid_o = ram_rvalid_i & pend_vld_q & (pend_own_q == OWN_B);
    a_rdata_o  = {Width{1'b0}};
    b_rdata_o  = {Width{1'b0}};
    if (a_rvalid_o) begin
      a_rdata_o = ram_rdata_i;
    end else if (b_rvalid_o) begin
      b_rdata_o = ram_rdata_i;
    end else begin
      a_rdata_o = {Width{1'b0}};
    end
  end

endmodule
